// File: rtl/tick_interval_timer.sv
// rtl/tick_interval_timer.sv - interval timer counting rising edges of a divided clock
module tick_interval_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         div_clk,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_reload,
  input  logic [W-1:0] load_val,
  output logic         tick,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         expire,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic         div_q;
  logic [W-1:0] reload_val;
  logic         ar;

  // div_clk is treated purely as data; its rising edge becomes a one-cycle tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= 1'b0;
      tick  <= 1'b0;
    end else begin
      div_q <= div_clk;
      tick  <= div_clk & ~div_q;
    end
  end

  // Priority each cycle: stop, then start, then the tick event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      busy       <= 1'b0;
      expire     <= 1'b0;
      done       <= 1'b0;
      reload_val <= '0;
      ar         <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (stop) begin
        if (state != IDLE) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      end else if (start) begin
        reload_val <= load_val;
        ar         <= auto_reload;
        if (load_val != '0) begin
          count <= load_val;
          state <= RUN;
          busy  <= 1'b1;
          done  <= 1'b0;
        end else begin
          // A zero interval expires at once and never enters RUN.
          count  <= '0;
          expire <= 1'b1;
          busy   <= 1'b0;
          if (auto_reload) begin
            state <= IDLE;
            done  <= 1'b0;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
      end else if (state == RUN && tick) begin
        if (count > W'(1)) begin
          count <= count - W'(1);
        end else if (ar) begin
          count  <= reload_val;
          expire <= 1'b1;
        end else begin
          count  <= '0;
          expire <= 1'b1;
          state  <= DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_interval_timer.sv
// tb/tb_tick_interval_timer.sv - bench for tick_interval_timer
module tb_tick_interval_timer;

  logic        clk;
  logic        rst;
  logic        div_clk;
  logic        start;
  logic        stop;
  logic        auto_reload;
  logic [15:0] load_val;
  logic        tick;
  logic [15:0] count;
  logic        busy;
  logic        expire;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  tick_interval_timer #(.W(16)) dut (
    .clk(clk), .rst(rst), .div_clk(div_clk), .start(start), .stop(stop),
    .auto_reload(auto_reload), .load_val(load_val), .tick(tick), .count(count),
    .busy(busy), .expire(expire), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sp;
    logic        ar;
    logic [15:0] ld;
    logic        dv;
    logic        e_tick;
    logic [15:0] e_count;
    logic        e_busy;
    logic        e_expire;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic sp, input logic ar,
                              input logic [15:0] ld, input logic dv,
                              input logic et, input logic [15:0] ec,
                              input logic eb, input logic ee, input logic ed);
    vec_t v;
    v.st = st; v.sp = sp; v.ar = ar; v.ld = ld; v.dv = dv;
    v.e_tick = et; v.e_count = ec; v.e_busy = eb; v.e_expire = ee; v.e_done = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic sp, input logic ar,
                       input logic [15:0] ld, input logic dv);
    start = st; stop = sp; auto_reload = ar; load_val = ld; div_clk = dv;
  endtask

  task automatic check_all(input string tag, input logic et, input logic [15:0] ec,
                           input logic eb, input logic ee, input logic ed);
    check({tag, ".tick"},   32'(tick),   32'(et));
    check({tag, ".count"},  32'(count),  32'(ec));
    check({tag, ".busy"},   32'(busy),   32'(eb));
    check({tag, ".expire"}, 32'(expire), 32'(ee));
    check({tag, ".done"},   32'(done),   32'(ed));
  endtask

  // Reference model: timer described as running/finished flags and an integer count.
  bit m_prev_div, m_tick, m_run, m_fin, m_expire, m_ar;
  int m_count, m_reload;

  task automatic model_edge();
    bit new_tick;
    new_tick   = div_clk && !m_prev_div;
    m_prev_div = div_clk;
    m_expire   = 1'b0;
    if (stop) begin
      m_run = 1'b0;
      m_fin = 1'b0;
    end else if (start) begin
      m_reload = int'(load_val);
      m_ar     = auto_reload;
      if (load_val != 0) begin
        m_count = int'(load_val); m_run = 1'b1; m_fin = 1'b0;
      end else begin
        m_count = 0; m_expire = 1'b1; m_run = 1'b0; m_fin = !auto_reload;
      end
    end else if (m_run && m_tick) begin
      if (m_count > 1) m_count = m_count - 1;
      else begin
        m_expire = 1'b1;
        if (m_ar) m_count = m_reload;
        else begin m_count = 0; m_run = 1'b0; m_fin = 1'b1; end
      end
    end
    m_tick = new_tick;
  endtask

  initial begin
    int ticks;
    int idle_bad;
    int div_cnt;

    rst = 1'b0;
    drive(0, 0, 0, 16'd0, 0);
    step(); step();
    check_all("reset", 0, 16'd0, 0, 0, 0);
    rst = 1'b1;

    // Basic tick: three rising edges of a 10-high/10-low wave.
    ticks = 0;
    idle_bad = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) begin
        div_clk = (i < 10);
        step();
        if (tick) begin
          ticks++;
          check($sformatf("tick_pos%0d_%0d", r, i), 32'(i), 32'd0);
        end
        if (count != 16'd0 || busy) idle_bad++;
      end
    end
    check("tick_total", 32'(ticks), 32'd3);
    check("idle_during_ticks", 32'(idle_bad), 32'd0);

    // One-shot, load 3
    vecs.push_back(mk(1,0,0,16'd3,0, 0,16'd3,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,1, 1,16'd3,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,1, 0,16'd2,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd2,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,1, 1,16'd2,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd1,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,1, 1,16'd1,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd0,0,1,1));
    vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd0,0,0,1));
    vecs.push_back(mk(0,0,0,16'd0,1, 1,16'd0,0,0,1));
    vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd0,0,0,1));
    vecs.push_back(mk(0,1,0,16'd0,0, 0,16'd0,0,0,0));
    // Auto-reload, load 2
    vecs.push_back(mk(1,0,1,16'd2,0, 0,16'd2,1,0,0));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0,0,0,16'd0,1, 1,16'd2,1,0,0));
      vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd1,1,0,0));
      vecs.push_back(mk(0,0,0,16'd0,1, 1,16'd1,1,0,0));
      vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd2,1,1,0));
    end
    vecs.push_back(mk(0,1,0,16'd0,0, 0,16'd2,0,0,0));
    // Stop after two ticks of a 5 interval, then start+stop together
    vecs.push_back(mk(1,0,0,16'd5,0, 0,16'd5,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,1, 1,16'd5,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd4,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,1, 1,16'd4,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd3,1,0,0));
    vecs.push_back(mk(0,1,0,16'd0,0, 0,16'd3,0,0,0));
    vecs.push_back(mk(1,1,0,16'd9,0, 0,16'd3,0,0,0));
    // Restart in RUN coinciding with a tick: loads 4, no decrement
    vecs.push_back(mk(1,0,0,16'd6,0, 0,16'd6,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,1, 1,16'd6,1,0,0));
    vecs.push_back(mk(1,0,0,16'd4,0, 0,16'd4,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd4,1,0,0));
    vecs.push_back(mk(0,1,0,16'd0,0, 0,16'd4,0,0,0));
    // Stop with a coincident tick: tick discarded, count held
    vecs.push_back(mk(1,0,0,16'd3,0, 0,16'd3,1,0,0));
    vecs.push_back(mk(0,0,0,16'd0,1, 1,16'd3,1,0,0));
    vecs.push_back(mk(0,1,0,16'd0,1, 0,16'd3,0,0,0));
    vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd3,0,0,0));
    // Zero load, one-shot then auto-reload
    vecs.push_back(mk(1,0,0,16'd0,0, 0,16'd0,0,1,1));
    vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd0,0,0,1));
    vecs.push_back(mk(0,1,0,16'd0,0, 0,16'd0,0,0,0));
    vecs.push_back(mk(1,0,1,16'd0,0, 0,16'd0,0,1,0));
    vecs.push_back(mk(0,0,0,16'd0,0, 0,16'd0,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].ar, vecs[i].ld, vecs[i].dv);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_tick, vecs[i].e_count,
                vecs[i].e_busy, vecs[i].e_expire, vecs[i].e_done);
    end

    // Asynchronous reset while count is 7
    drive(1, 0, 0, 16'd7, 0);
    step();
    drive(0, 0, 0, 16'd0, 0);
    check_all("pre_async", 0, 16'd7, 1, 0, 0);
    #3;
    rst = 1'b0;
    #1;
    check_all("async_rst", 0, 16'd0, 0, 0, 0);
    step();
    rst = 1'b1;
    step(); step();
    check_all("after_rst", 0, 16'd0, 0, 0, 0);
    drive(1, 0, 0, 16'd2, 0);
    step();
    check_all("restart_after_rst", 0, 16'd2, 1, 0, 0);
    drive(0, 1, 0, 16'd0, 0);
    step();
    check_all("stop_after_rst", 0, 16'd2, 0, 0, 0);

    // Randomized run against the reference model
    m_prev_div = 0; m_tick = 0; m_run = 0; m_fin = 0; m_expire = 0; m_ar = 0;
    m_count = 2; m_reload = 2;
    div_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (div_cnt == 0) begin
        div_clk = ~div_clk;
        div_cnt = int'($urandom_range(1, 6));
      end
      div_cnt--;
      start       = ($urandom_range(0, 99) < 6);
      stop        = ($urandom_range(0, 99) < 3);
      auto_reload = 1'($urandom_range(0, 1));
      load_val    = 16'($urandom_range(0, 4));
      model_edge();
      step();
      check_all($sformatf("rand%0d", c), m_tick, 16'(m_count), m_run, m_expire, m_fin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
